// File: rtl/decode_imm_stage_pkg.sv
// decode_imm_stage_pkg
//   Shared decode constants: immediate class codes, RV64 major opcodes,
//   skid-buffer state encoding and the buffered entry layout. The control
//   unit imports the same opcode and immediate-class definitions.
package decode_imm_stage_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_NONE = 3'b111
  } imm_type_e;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OP_32    = 7'b0111011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    imm_type_e   imm_type;
    logic [63:0] imm;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/decode_imm_stage_sign_extend.sv
// sign_extend
//   Builds the 64-bit sign-extended immediate for a given immediate class.
//   i_instr    : raw instruction word
//   i_imm_type : immediate class (IMM_NONE yields 0)
//   o_imm      : sign-extended immediate
module sign_extend
  import decode_imm_stage_pkg::*;
(
  input  logic [31:0] i_instr,
  input  imm_type_e   i_imm_type,
  output logic [63:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_imm_type)
      IMM_I: o_imm = {{52{i_instr[31]}}, i_instr[31:20]};
      IMM_S: o_imm = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm = {{51{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U: o_imm = {{32{i_instr[31]}}, i_instr[31:12], 12'b0};
      IMM_J: o_imm = {{43{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_imm_stage.sv
// decode_imm_stage
//   Classifies the incoming instruction, generates its immediate and holds
//   the result in a 2-entry skid buffer (main, skid) between fetch and
//   execute. in_ready is registered so fetch never sees a combinational
//   path from out_ready.
//   clk/rst          : clock, asynchronous active-high reset
//   in_valid/in_ready, in_instr, in_pc : fetch handshake and payload
//   flush            : drop every buffered entry (branch redirect)
//   out_valid/out_ready, out_*         : execute handshake, main entry
//   illegal_cnt      : saturating count of illegal entries delivered
module decode_imm_stage
  import decode_imm_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [63:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic [2:0]  out_imm_type,
  output logic [63:0] out_imm,
  output logic        out_illegal,
  output logic [15:0] illegal_cnt
);

  imm_type_e   w_type;
  logic        w_illegal;
  logic [63:0] w_imm;
  entry_t      w_in_entry;

  buf_state_e  r_state, w_state_nxt;
  entry_t      r_main, r_skid;
  logic        r_in_ready;
  logic [15:0] r_illegal_cnt;

  logic        w_acc, w_deq;
  logic        w_load_main, w_main_from_skid, w_load_skid;

  // Opcode classifier; the low two bits must be 11 for any 32-bit encoding.
  always_comb begin
    w_type    = IMM_NONE;
    w_illegal = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (in_instr[6:0])
        OP_LOAD, OP_MISC_MEM, OP_IMM, OP_IMM_32, OP_JALR, OP_SYSTEM:
                             w_type = IMM_I;
        OP_STORE:            w_type = IMM_S;
        OP_BRANCH:           w_type = IMM_B;
        OP_LUI, OP_AUIPC:    w_type = IMM_U;
        OP_JAL:              w_type = IMM_J;
        OP_OP, OP_OP_32:     w_type = IMM_NONE;
        default:             w_illegal = 1'b1;
      endcase
    end
  end

  sign_extend u_sign_extend (
    .i_instr    (in_instr),
    .i_imm_type (w_type),
    .o_imm      (w_imm)
  );

  always_comb begin
    w_in_entry.instr    = in_instr;
    w_in_entry.pc       = in_pc;
    w_in_entry.imm_type = w_type;
    w_in_entry.imm      = w_imm;
    w_in_entry.illegal  = w_illegal;
  end

  assign w_acc = in_valid & r_in_ready;
  assign w_deq = (r_state != ST_EMPTY) & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_acc) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
        end
        ST_ONE: begin
          if (w_acc && !w_deq) begin
            w_state_nxt = ST_TWO;
            w_load_skid = 1'b1;
          end else if (w_acc && w_deq) begin
            w_load_main = 1'b1;
          end else if (w_deq) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        // in_ready is low in TWO, so no accept can arrive here.
        ST_TWO: if (w_deq) begin
          w_state_nxt      = ST_ONE;
          w_main_from_skid = 1'b1;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_EMPTY;
      r_main        <= '0;
      r_skid        <= '0;
      r_in_ready    <= 1'b1;
      r_illegal_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      // Registered ready reflects next state, so it is exact, not pessimistic.
      r_in_ready <= (w_state_nxt != ST_TWO);
      if (w_load_main)           r_main <= w_in_entry;
      else if (w_main_from_skid) r_main <= r_skid;
      if (w_load_skid)           r_skid <= w_in_entry;
      // A flush overrides the dequeue, so that entry is not counted.
      if (w_deq && !flush && r_main.illegal && (r_illegal_cnt != 16'hFFFF))
        r_illegal_cnt <= r_illegal_cnt + 16'd1;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = (r_state != ST_EMPTY);
  assign out_instr    = r_main.instr;
  assign out_pc       = r_main.pc;
  assign out_imm_type = r_main.imm_type;
  assign out_imm      = r_main.imm;
  assign out_illegal  = r_main.illegal;
  assign illegal_cnt  = r_illegal_cnt;

endmodule
